// File: rtl/column_move_scheduler.sv
// column_move_scheduler: launches the column units, waits for every done flag, then
// drains the column FIFOs round-robin onto one tagged move stream. Optional watchdog: WATCHDOG_EN.
module column_move_scheduler #(
  parameter int NCOL        = 8,
  parameter int DW          = 160,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               col_start,
  input  logic [NCOL-1:0]    col_done,
  input  logic [NCOL-1:0]    col_fifo_empty,
  input  logic [NCOL*DW-1:0] col_fifo_data,
  output logic [NCOL-1:0]    col_rden,
  output logic               mv_valid,
  input  logic               mv_ready,
  output logic [DW-1:0]      mv_data,
  output logic [2:0]         mv_col,
  output logic               busy,
  output logic               gen_done,
  output logic               wd_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_DONE,
    S_SELECT,
    S_READ,
    S_PRESENT,
    S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic            col_start_q, col_start_d;
  logic [NCOL-1:0] col_rden_q, col_rden_d;
  logic            mv_valid_q, mv_valid_d;
  logic [DW-1:0]   mv_data_q, mv_data_d;
  logic [2:0]      mv_col_q, mv_col_d;
  logic [2:0]      sel_q, sel_d;
  logic [2:0]      rr_q, rr_d;
  logic            busy_q, busy_d;
  logic            gen_done_q, gen_done_d;
  logic            first_q, first_d;

  logic            all_done;
  logic            wd_timeout;
  logic            found;
  logic [2:0]      pick;
  logic [DW-1:0]   rd_word;

  // The first WAIT_DONE cycle is masked: columns are still leaving reset.
  assign all_done = !first_q && (&col_done);

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NCOL) s = s - NCOL;
    return 3'(s);
  endfunction

  // Round-robin search for the first non-empty FIFO at or after rr.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int off = 0; off < NCOL; off++) begin
      if (!found && !col_fifo_empty[wrap_idx(rr_q, off)]) begin
        found = 1'b1;
        pick  = wrap_idx(rr_q, off);
      end
    end
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NCOL; i++) begin
      if (sel_q == 3'(i)) rd_word = col_fifo_data[i*DW +: DW];
    end
  end

`ifdef WATCHDOG_EN
  logic [7:0] wd_cnt_q, wd_cnt_d;
  logic       wd_err_q, wd_err_d;

  assign wd_timeout = (wd_cnt_q == 8'(TIMEOUT_CYC));

  always_comb begin
    wd_cnt_d = '0;
    wd_err_d = wd_err_q;
    if (state_q == S_WAIT_DONE) begin
      wd_cnt_d = wd_cnt_q + 8'd1;
      if (!all_done && wd_timeout) wd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q <= '0;
      wd_err_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      wd_err_q <= wd_err_d;
    end
  end

  assign wd_err = wd_err_q;
`else
  assign wd_timeout = 1'b0;
  assign wd_err     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    col_start_d = 1'b0;
    col_rden_d  = '0;
    mv_valid_d  = mv_valid_q;
    mv_data_d   = mv_data_q;
    mv_col_d    = mv_col_q;
    sel_d       = sel_q;
    rr_d        = rr_q;
    busy_d      = busy_q;
    gen_done_d  = 1'b0;
    first_d     = first_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LAUNCH;
          busy_d      = 1'b1;
          col_start_d = 1'b1;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT_DONE;
        first_d = 1'b1;
      end
      S_WAIT_DONE: begin
        first_d = 1'b0;
        if (all_done) begin
          state_d = S_SELECT;
        end else if (wd_timeout) begin
          state_d    = S_FINISH;
          gen_done_d = 1'b1;
        end
      end
      S_SELECT: begin
        if (found) begin
          col_rden_d[pick] = 1'b1;
          sel_d            = pick;
          state_d          = S_READ;
        end else begin
          state_d    = S_FINISH;
          gen_done_d = 1'b1;
        end
      end
      S_READ: begin
        mv_data_d  = rd_word;
        mv_col_d   = sel_q;
        mv_valid_d = 1'b1;
        state_d    = S_PRESENT;
      end
      S_PRESENT: begin
        if (mv_ready) begin
          mv_valid_d = 1'b0;
          rr_d       = (sel_q == 3'(NCOL-1)) ? 3'd0 : sel_q + 3'd1;
          state_d    = S_SELECT;
        end
      end
      S_FINISH: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      col_start_q <= 1'b0;
      col_rden_q  <= '0;
      mv_valid_q  <= 1'b0;
      mv_data_q   <= '0;
      mv_col_q    <= '0;
      sel_q       <= '0;
      rr_q        <= '0;
      busy_q      <= 1'b0;
      gen_done_q  <= 1'b0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_start_q <= col_start_d;
      col_rden_q  <= col_rden_d;
      mv_valid_q  <= mv_valid_d;
      mv_data_q   <= mv_data_d;
      mv_col_q    <= mv_col_d;
      sel_q       <= sel_d;
      rr_q        <= rr_d;
      busy_q      <= busy_d;
      gen_done_q  <= gen_done_d;
      first_q     <= first_d;
    end
  end

  assign col_start = col_start_q;
  assign col_rden  = col_rden_q;
  assign mv_valid  = mv_valid_q;
  assign mv_data   = mv_data_q;
  assign mv_col    = mv_col_q;
  assign busy      = busy_q;
  assign gen_done  = gen_done_q;

endmodule

// File: tb/tb_column_move_scheduler.sv
// tb_column_move_scheduler: directed bench with a small FIFO model per column and a
// stream monitor; expected values are hand-derived from the scheduler's cycle behaviour.
module tb_column_move_scheduler;
  localparam int NCOL        = 8;
  localparam int DW          = 160;
  localparam int TIMEOUT_CYC = 20;

  localparam logic [DW-1:0] WA = {40{4'hA}};
  localparam logic [DW-1:0] WB = {40{4'hB}};
  localparam logic [DW-1:0] WC = {40{4'hC}};
  localparam logic [DW-1:0] WD = {40{4'hD}};
  localparam logic [DW-1:0] WE = {40{4'hE}};

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic               col_start;
  logic [NCOL-1:0]    col_done;
  logic [NCOL-1:0]    col_fifo_empty;
  logic [NCOL*DW-1:0] col_fifo_data;
  logic [NCOL-1:0]    col_rden;
  logic               mv_valid;
  logic               mv_ready;
  logic [DW-1:0]      mv_data;
  logic [2:0]         mv_col;
  logic               busy;
  logic               gen_done;
  logic               wd_err;

  always #5 clk = ~clk;

  column_move_scheduler #(
    .NCOL(NCOL),
    .DW(DW),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .col_start(col_start),
    .col_done(col_done),
    .col_fifo_empty(col_fifo_empty),
    .col_fifo_data(col_fifo_data),
    .col_rden(col_rden),
    .mv_valid(mv_valid),
    .mv_ready(mv_ready),
    .mv_data(mv_data),
    .mv_col(mv_col),
    .busy(busy),
    .gen_done(gen_done),
    .wd_err(wd_err)
  );

  // Column FIFO model: head word is presented, a strobe pops it at the clock edge.
  logic [DW-1:0] mem [NCOL][16];
  int wr_ptr [NCOL];
  int rd_ptr [NCOL];

  for (genvar g = 0; g < NCOL; g++) begin : g_fifo
    assign col_fifo_data[g*DW +: DW] = mem[g][rd_ptr[g] % 16];
    assign col_fifo_empty[g]         = (wr_ptr[g] == rd_ptr[g]);
  end

  int n_words = 0, n_rden = 0, n_multi = 0, n_bad_rden = 0;
  int n_col_start = 0, n_gen_done = 0;
  logic [DW-1:0] log_data [64];
  int log_col [64];

  always @(posedge clk) begin
    if ($countones(col_rden) > 1) n_multi <= n_multi + 1;
    n_rden <= n_rden + $countones(col_rden);
    for (int i = 0; i < NCOL; i++) begin
      if (col_rden[i]) begin
        if (wr_ptr[i] == rd_ptr[i]) n_bad_rden <= n_bad_rden + 1;
        else rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
    if (col_start) n_col_start <= n_col_start + 1;
    if (gen_done) n_gen_done <= n_gen_done + 1;
    if (mv_valid && mv_ready && n_words < 64) begin
      log_data[n_words] <= mv_data;
      log_col[n_words]  <= int'(mv_col);
      n_words           <= n_words + 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [NCOL-1:0] done, input logic rdy);
    start    = s;
    col_done = done;
    mv_ready = rdy;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clearFifos();
    for (int i = 0; i < NCOL; i++) wr_ptr[i] = rd_ptr[i];
  endtask

  task automatic pushWord(input int c, input logic [DW-1:0] w);
    mem[c][wr_ptr[c] % 16] = w;
    wr_ptr[c]++;
  endtask

  task automatic waitValid(input string tag, input int limit);
    int n;
    n = 0;
    while (!mv_valid && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput(tag, mv_valid, 1);
  endtask

  task automatic waitGenDone(input string tag, input int limit);
    int n;
    n = 0;
    while (!gen_done && n < limit) begin
      tick(1);
      n++;
    end
    checkOutput(tag, gen_done, 1);
  endtask

  initial begin
    int bw, bcs, bgd, brd, drops, n;

    for (int i = 0; i < NCOL; i++) begin
      wr_ptr[i] = 0;
      for (int j = 0; j < 16; j++) mem[i][j] = '0;
    end
    reset = 1'b0;
    applyStimulus(0, '0, 0);
    tick(2);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mv_valid", mv_valid, 0);
    checkOutput("rst_col_start", col_start, 0);
    checkOutput("rst_col_rden", col_rden, 0);
    checkOutput("rst_gen_done", gen_done, 0);
    checkOutput("rst_wd_err", wd_err, 0);
    reset = 1'b1;
    tick(2);

    $display("[TB] order test: FIFO3 {A,B}, FIFO5 {C}");
    clearFifos();
    pushWord(3, WA);
    pushWord(3, WB);
    pushWord(5, WC);
    bw = n_words; bcs = n_col_start; bgd = n_gen_done; brd = n_rden;
    applyStimulus(1, '0, 1);
    tick(1);
    applyStimulus(0, '0, 1);
    checkOutput("t2_col_start_hi", col_start, 1);
    checkOutput("t2_busy_hi", busy, 1);
    tick(1);
    checkOutput("t2_col_start_lo", col_start, 0);
    tick(10);
    applyStimulus(0, '1, 1);
    waitGenDone("t2_gen_done", 60);
    checkOutput("t2_busy_in_done", busy, 1);
    tick(1);
    checkOutput("t2_gen_done_pulse", gen_done, 0);
    checkOutput("t2_busy_lo", busy, 0);
    checkOutput("t2_words", n_words - bw, 3);
    checkOutput("t2_w0_col", log_col[bw], 3);
    checkOutput("t2_w0_data", log_data[bw], WA);
    checkOutput("t2_w1_col", log_col[bw+1], 5);
    checkOutput("t2_w1_data", log_data[bw+1], WC);
    checkOutput("t2_w2_col", log_col[bw+2], 3);
    checkOutput("t2_w2_data", log_data[bw+2], WB);
    checkOutput("t2_col_start_cnt", n_col_start - bcs, 1);
    checkOutput("t2_gen_done_cnt", n_gen_done - bgd, 1);
    checkOutput("t2_rden_cnt", n_rden - brd, 3);
    applyStimulus(0, '0, 0);
    tick(2);

    $display("[TB] reset while a word is presented");
    clearFifos();
    pushWord(6, WD);
    bgd = n_gen_done;
    applyStimulus(1, '0, 0);
    tick(1);
    applyStimulus(0, '0, 0);
    tick(3);
    applyStimulus(0, '1, 0);
    waitValid("t1_valid_seen", 40);
    checkOutput("t1_mv_col_pre", mv_col, 6);
    reset = 1'b0;
    #1;
    checkOutput("t1_mv_valid", mv_valid, 0);
    checkOutput("t1_mv_data", mv_data, '0);
    checkOutput("t1_mv_col", mv_col, 0);
    checkOutput("t1_busy", busy, 0);
    checkOutput("t1_col_rden", col_rden, 0);
    checkOutput("t1_gen_done", gen_done, 0);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(0, '0, 0);
    tick(3);
    checkOutput("t1_no_resume_busy", busy, 0);
    checkOutput("t1_no_resume_valid", mv_valid, 0);
    checkOutput("t1_no_gen_done", n_gen_done - bgd, 0);

    $display("[TB] backpressure hold");
    clearFifos();
    pushWord(2, WE);
    bw = n_words; brd = n_rden;
    applyStimulus(1, '0, 0);
    tick(1);
    applyStimulus(0, '0, 0);
    tick(3);
    applyStimulus(0, '1, 0);
    waitValid("t3_valid_seen", 40);
    for (int c = 0; c < 5; c++) begin
      checkOutput("t3_hold_valid", mv_valid, 1);
      checkOutput("t3_hold_data", mv_data, WE);
      checkOutput("t3_hold_col", mv_col, 2);
      tick(1);
    end
    checkOutput("t3_valid_cycle6", mv_valid, 1);
    applyStimulus(0, '1, 1);
    tick(1);
    checkOutput("t3_valid_dropped", mv_valid, 0);
    waitGenDone("t3_gen_done", 40);
    tick(1);
    checkOutput("t3_words", n_words - bw, 1);
    checkOutput("t3_word_data", log_data[bw], WE);
    checkOutput("t3_rden_cnt", n_rden - brd, 1);
    applyStimulus(0, '0, 0);
    tick(2);

    $display("[TB] all FIFOs empty, start during gen_done");
    clearFifos();
    brd = n_rden; bcs = n_col_start; bgd = n_gen_done;
    applyStimulus(1, '0, 1);
    tick(1);
    applyStimulus(0, '0, 1);
    tick(4);
    applyStimulus(0, '1, 1);
    tick(1);
    checkOutput("t4_gen_done_early", gen_done, 0);
    tick(1);
    checkOutput("t4_gen_done_2cyc", gen_done, 1);
    applyStimulus(1, '0, 1);
    tick(1);
    applyStimulus(0, '0, 1);
    checkOutput("t4_start_ignored_busy", busy, 0);
    checkOutput("t4_start_ignored_cs", col_start, 0);
    tick(2);
    checkOutput("t4_rden_none", n_rden - brd, 0);
    checkOutput("t4_col_start_cnt", n_col_start - bcs, 1);
    checkOutput("t4_gen_done_cnt", n_gen_done - bgd, 1);

    $display("[TB] start during drain");
    clearFifos();
    pushWord(1, WA);
    pushWord(1, WB);
    pushWord(4, WC);
    bw = n_words; bcs = n_col_start; bgd = n_gen_done;
    applyStimulus(1, '0, 1);
    tick(1);
    applyStimulus(0, '0, 1);
    tick(3);
    applyStimulus(0, '1, 1);
    waitValid("t5_valid_seen", 40);
    applyStimulus(1, '1, 1);
    tick(1);
    applyStimulus(0, '1, 1);
    drops = 0;
    n = 0;
    while (!gen_done && n < 60) begin
      if (!busy) drops++;
      tick(1);
      n++;
    end
    checkOutput("t5_gen_done", gen_done, 1);
    checkOutput("t5_busy_held", drops, 0);
    tick(1);
    checkOutput("t5_words", n_words - bw, 3);
    checkOutput("t5_w0_col", log_col[bw], 4);
    checkOutput("t5_w1_col", log_col[bw+1], 1);
    checkOutput("t5_w1_data", log_data[bw+1], WA);
    checkOutput("t5_w2_data", log_data[bw+2], WB);
    applyStimulus(0, '0, 1);
    tick(5);
    checkOutput("t5_gen_done_cnt", n_gen_done - bgd, 1);
    checkOutput("t5_col_start_cnt", n_col_start - bcs, 1);
    checkOutput("t5_busy_lo", busy, 0);
    checkOutput("t5_rden_onehot", n_multi, 0);
    checkOutput("t5_rden_on_empty", n_bad_rden, 0);

    $display("[TB] one column never done");
    clearFifos();
    bgd = n_gen_done;
    applyStimulus(1, 8'h7F, 1);
    tick(1);
    applyStimulus(0, 8'h7F, 1);
`ifdef WATCHDOG_EN
    tick(21);
    checkOutput("t6_gen_done_early", gen_done, 0);
    tick(1);
    checkOutput("t6_gen_done", gen_done, 1);
    checkOutput("t6_wd_err", wd_err, 1);
    tick(2);
    checkOutput("t6_wd_err_sticky", wd_err, 1);
    checkOutput("t6_busy_lo", busy, 0);
    checkOutput("t6_gen_done_cnt", n_gen_done - bgd, 1);
`else
    tick(101);
    checkOutput("t6_still_busy", busy, 1);
    checkOutput("t6_wd_err_zero", wd_err, 0);
    checkOutput("t6_no_gen_done", n_gen_done - bgd, 0);
`endif
    reset = 1'b0;
    applyStimulus(0, '0, 0);
    tick(1);
    reset = 1'b1;
    tick(2);
    checkOutput("t6_abort_busy", busy, 0);
    checkOutput("t6_abort_wd_err", wd_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
